// File: rtl/popcnt_pkg.sv
// Shared types and width helpers for the ones-count accumulator.
package popcnt_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  typedef logic [1:0] cnt2_t;

  function automatic int sum_width(input int window);
    return $clog2(3 * window + 1);
  endfunction

endpackage

// File: rtl/popcnt_accum_settle_filter.sv
// Deglitch filter: accepts a 2-bit count once it has been stable for SETTLE
// edges, then ignores one edge so the upstream may change value safely.
module settle_filter
  import popcnt_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  cnt2_t d,
  output logic  accept,
  output logic  ack
);

  localparam int STAB_W = $clog2(SETTLE + 1);

  cnt2_t             prev_q;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_d;
  logic [STAB_W-1:0] stab_next_s;
  logic              ack_q;

  // The edge right after an accept is the blank edge and never counts.
  always_comb begin
    stab_next_s = stab_q;
    stab_d      = stab_q;
    accept      = 1'b0;
    if (!en || ack_q) begin
      stab_d = '0;
    end else begin
      if (d == prev_q) begin
        if (stab_q != STAB_W'(SETTLE)) begin
          stab_next_s = stab_q + STAB_W'(1);
        end else begin
          stab_next_s = stab_q;
        end
      end else begin
        stab_next_s = STAB_W'(1);
      end
      if (stab_next_s == STAB_W'(SETTLE)) begin
        accept = 1'b1;
        stab_d = '0;
      end else begin
        stab_d = stab_next_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 2'b00;
      stab_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      prev_q <= d;
      stab_q <= stab_d;
      ack_q  <= accept;
    end
  end

  assign ack = ack_q;

endmodule

// File: rtl/popcnt_accum.sv
// Frames WINDOW deglitched ones-counts into a sum and maximum and hands the
// result downstream over a valid/ready handshake.
module popcnt_accum
  import popcnt_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int SETTLE = 2,
  parameter int SUM_W  = sum_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             y1,
  input  logic             y0,
  output logic             in_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [1:0]       out_max
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  cnt2_t              max_q, max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;
  cnt2_t              out_max_q, out_max_d;

  cnt2_t              sample_s;
  logic               en_s;
  logic               accept_s;
  logic               last_s;
  logic               handshake_s;
  logic [SUM_W-1:0]   sum_acc_s;
  cnt2_t              max_acc_s;

  assign sample_s    = {y1, y0};
  assign en_s        = in_valid && (state_q == COLLECT);
  assign last_s      = accept_s && (cnt_q == CNT_W'(WINDOW - 1));
  assign handshake_s = out_valid_q && out_ready;
  assign sum_acc_s   = sum_q + SUM_W'(sample_s);
  assign max_acc_s   = (sample_s > max_q) ? sample_s : max_q;

  settle_filter #(
    .SETTLE(SETTLE)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .en    (en_s),
    .d     (sample_s),
    .accept(accept_s),
    .ack   (in_ack)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = COLLECT;
        end
      end
      DONE: begin
        if (handshake_s) begin
          state_d = COLLECT;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Final totals are published on the accept that completes the frame.
  always_comb begin
    sum_d       = sum_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    case (state_q)
      COLLECT: begin
        if (accept_s) begin
          sum_d = sum_acc_s;
          max_d = max_acc_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_s) begin
            out_valid_d = 1'b1;
            out_sum_d   = sum_acc_s;
            out_max_d   = max_acc_s;
          end else begin
            out_valid_d = 1'b0;
          end
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      DONE: begin
        if (handshake_s) begin
          sum_d       = '0;
          max_d       = 2'b00;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      max_q       <= 2'b00;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= 2'b00;
    end else begin
      sum_q       <= sum_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed bench for popcnt_accum: table of phases with hand-computed results
// plus explicit cycle-level sequences for latency and repeat spacing.
module tb_popcnt_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       y1;
  logic       y0;
  logic       in_ack;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_sum;
  logic [1:0] out_max;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       vld;
    logic [1:0] cnt;
    logic       rdy;
    int         cyc;
    int         acks;
    logic       ov;
    logic [4:0] sum;
    logic [1:0] mx;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  popcnt_accum #(
    .WINDOW(8),
    .SETTLE(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .y1       (y1),
    .y0       (y0),
    .in_ack   (in_ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_max  (out_max)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic r, input logic v,
                              input logic [1:0] c, input logic rd, input int cyc,
                              input int acks, input logic ov, input logic [4:0] s,
                              input logic [1:0] m);
    vec_t x;
    x.name = name; x.rst = r; x.vld = v; x.cnt = c; x.rdy = rd; x.cyc = cyc;
    x.acks = acks; x.ov = ov; x.sum = s; x.mx = m;
    return x;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [1:0] c, input logic rd);
    rst = r; in_valid = v; y1 = c[1]; y0 = c[0]; out_ready = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int acks;
    acks = 0;
    drive(v.rst, v.vld, v.cnt, v.rdy);
    for (int i = 0; i < v.cyc; i++) begin
      tick();
      if (in_ack === 1'b1) acks++;
    end
    n_vec++;
    if (acks != v.acks || out_valid !== v.ov || out_sum !== v.sum || out_max !== v.mx) begin
      n_bad++;
      $display("FAIL %s: got acks=%0d valid=%0b sum=%0d max=%0d, want acks=%0d valid=%0b sum=%0d max=%0d",
               v.name, acks, out_valid, out_sum, out_max, v.acks, v.ov, v.sum, v.mx);
    end
  endtask

  task automatic chk_ack(input string name, input logic exp);
    n_vec++;
    if (in_ack !== exp) begin
      n_bad++;
      $display("FAIL %s: in_ack=%0b want %0b", name, in_ack, exp);
    end
  endtask

  initial begin
    // Reset, full truth-table frame, backpressure, handshake, glitch train.
    tbl_a.push_back(mk("reset",      1'b1, 1'b0, 2'd0, 1'b0, 2, 0, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_0",       1'b0, 1'b1, 2'd0, 1'b0, 3, 1, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_1a",      1'b0, 1'b1, 2'd1, 1'b0, 3, 1, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_1b",      1'b0, 1'b1, 2'd1, 1'b0, 3, 1, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_2a",      1'b0, 1'b1, 2'd2, 1'b0, 3, 1, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_1c",      1'b0, 1'b1, 2'd1, 1'b0, 3, 1, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_2b",      1'b0, 1'b1, 2'd2, 1'b0, 3, 1, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_2c",      1'b0, 1'b1, 2'd2, 1'b0, 3, 1, 1'b0, 5'd0,  2'd0));
    tbl_a.push_back(mk("tt_3",       1'b0, 1'b1, 2'd3, 1'b0, 3, 1, 1'b1, 5'd12, 2'd3));
    tbl_a.push_back(mk("backpress",  1'b0, 1'b1, 2'd1, 1'b0, 6, 0, 1'b1, 5'd12, 2'd3));
    tbl_a.push_back(mk("handshake1", 1'b0, 1'b0, 2'd1, 1'b1, 1, 0, 1'b0, 5'd12, 2'd3));
    for (int i = 0; i < 8; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'd1 : 2'd2;
      tbl_a.push_back(mk($sformatf("glitch_%0d", i), 1'b0, 1'b1, g, 1'b0, 1, 0, 1'b0, 5'd12, 2'd3));
    end
    tbl_a.push_back(mk("glitch_hold", 1'b0, 1'b1, 2'd2, 1'b0, 2, 1, 1'b0, 5'd12, 2'd3));

    // Finish frame 2 (2 + 1 + six zeros), then reset mid-frame and a frame of 3s.
    for (int i = 0; i < 6; i++) begin
      tbl_b.push_back(mk($sformatf("zeros_%0d", i), 1'b0, 1'b1, 2'd0, 1'b0, 3, 1,
                         (i == 5) ? 1'b1 : 1'b0, (i == 5) ? 5'd3 : 5'd12, (i == 5) ? 2'd2 : 2'd3));
    end
    tbl_b.push_back(mk("handshake2", 1'b0, 1'b0, 2'd0, 1'b1, 1, 0, 1'b0, 5'd3, 2'd2));
    for (int i = 0; i < 5; i++) begin
      tbl_b.push_back(mk($sformatf("pre_rst_%0d", i), 1'b0, 1'b1, 2'd3, 1'b0,
                         (i == 4) ? 2 : 3, 1, 1'b0, 5'd3, 2'd2));
    end
    tbl_b.push_back(mk("mid_reset", 1'b1, 1'b1, 2'd3, 1'b0, 1, 0, 1'b0, 5'd0, 2'd0));
    for (int i = 0; i < 8; i++) begin
      tbl_b.push_back(mk($sformatf("threes_%0d", i), 1'b0, 1'b1, 2'd3, 1'b0, 3, 1,
                         (i == 7) ? 1'b1 : 1'b0, (i == 7) ? 5'd24 : 5'd0, (i == 7) ? 2'd3 : 2'd0));
    end
    tbl_b.push_back(mk("handshake3", 1'b0, 1'b0, 2'd0, 1'b1, 1, 0, 1'b0, 5'd24, 2'd3));

    drive(1'b1, 1'b0, 2'd0, 1'b0);

    foreach (tbl_a[i]) run_vec(tbl_a[i]);

    // Valid drop: ack lands on the second cycle after valid returns.
    drive(1'b0, 1'b1, 2'd1, 1'b0); tick(); chk_ack("vdrop_first", 1'b0);
    drive(1'b0, 1'b0, 2'd1, 1'b0); tick(); chk_ack("vdrop_gap",   1'b0);
    drive(1'b0, 1'b1, 2'd1, 1'b0); tick(); chk_ack("vdrop_ret1",  1'b0);
    tick(); chk_ack("vdrop_ret2", 1'b1);
    tick(); chk_ack("vdrop_blank", 1'b0);

    foreach (tbl_b[i]) run_vec(tbl_b[i]);

    // Repeated value: one ack every SETTLE+1 cycles, eight acks close the frame.
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 24; i++) begin
      tick();
      chk_ack($sformatf("repeat_%0d", i), (i % 3 == 1) ? 1'b1 : 1'b0);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_sum !== 5'd16 || out_max !== 2'd2) begin
      n_bad++;
      $display("FAIL repeat_frame: got valid=%0b sum=%0d max=%0d, want valid=1 sum=16 max=2",
               out_valid, out_sum, out_max);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
